// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with arbitrary modulus, wrap or saturate mode,
// sync clear, parallel load, combinational terminal count and registered
// wrap/error pulses. Chain stages by feeding one stage's tc to the next en.
module updown_counter_mod #(
    parameter int unsigned     WIDTH   = 3,
    parameter longint unsigned MODULUS = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             down,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    // Highest legal count, held at counter width so every compare is WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    // Reject illegal parameter combinations at elaboration.
    generate
        if ((WIDTH < 1) || (WIDTH > 32) || (MODULUS < 2) ||
            (MODULUS > (64'd1 << WIDTH))) begin : g_bad_params
            $error("updown_counter_mod: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_q_d;
    logic             w_wrap_d;
    logic             w_err_d;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_oor;

    assign w_at_max   = (r_q == MAX_Q);
    assign w_at_zero  = (r_q == '0);
    assign w_load_oor = (d > MAX_Q);

    // Next-state: clr beats load beats en; pulses default low every edge.
    always_comb begin
        w_q_d    = r_q;
        w_wrap_d = 1'b0;
        w_err_d  = 1'b0;
        if (clr) begin
            w_q_d = '0;
        end else if (load) begin
            if (w_load_oor) begin
                // Clamp so q can never leave 0..MODULUS-1.
                w_q_d   = MAX_Q;
                w_err_d = 1'b1;
            end else begin
                w_q_d = d;
            end
        end else if (en) begin
            if (down) begin
                if (!w_at_zero) begin
                    w_q_d = r_q - 1'b1;
                end else if (!sat) begin
                    w_q_d    = MAX_Q;
                    w_wrap_d = 1'b1;
                end
            end else begin
                if (!w_at_max) begin
                    w_q_d = r_q + 1'b1;
                end else if (!sat) begin
                    w_q_d    = '0;
                    w_wrap_d = 1'b1;
                end
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_d;
            r_wrap <= w_wrap_d;
            r_err  <= w_err_d;
        end
    end

    // Terminal count ignores sat so a saturated stage still reports its bound;
    // suppressed while clr/load override the count.
    always_comb begin
        tc = en & ~clr & ~load & (down ? w_at_zero : w_at_max);
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule
